mem_access_stage: RTL and testbench

//  Memory stage of the RV32I pipeline. Receives the ALU result, store data and

---
 rtl/mem_access_stage.sv | 222 ++++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// RV32I memory stage: runs one load/store at a time on a req/gnt/rvalid port,
// formats byte lanes, extends loads, flags misalignment and bus timeouts.
module mem_access_stage #(
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [31:0] alu_res,
    input  logic [31:0] mem_data,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd_in,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        mem_exc,
    output logic        bus_err
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [1:0]        off_q, off_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [2:0]        f3_q, f3_d;
    logic [4:0]        rd_q, rd_d;
    logic              stall_q, stall_d;
    logic              req_q, req_d;
    logic              wb_valid_q, wb_valid_d;
    logic [31:0]       wb_data_q, wb_data_d;
    logic [4:0]        wb_rd_q, wb_rd_d;
    logic              mem_exc_q, mem_exc_d;
    logic              bus_err_q, bus_err_d;

    logic              op_legal;
    logic [31:0]       rd_lane;
    logic [31:0]       load_val;

    function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   lane_be = 4'(4'b0001 << off);
            2'b01:   lane_be = 4'(4'b0011 << off);
            default: lane_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_fmt(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   store_fmt = {4{d[7:0]}};
            2'b01:   store_fmt = {2{d[15:0]}};
            default: store_fmt = d;
        endcase
    endfunction

    // Misalignment, unsupported size codes and read+write together are all rejected.
    always_comb begin
        op_legal = 1'b0;
        if (!(mem_read && mem_write)) begin
            case (funct3)
                3'b000:  op_legal = 1'b1;
                3'b001:  op_legal = !alu_res[0];
                3'b010:  op_legal = (alu_res[1:0] == 2'b00);
                3'b100:  op_legal = mem_read;
                3'b101:  op_legal = mem_read && !alu_res[0];
                default: op_legal = 1'b0;
            endcase
        end
    end

    // Select the addressed lane of the returned word and extend it.
    always_comb begin
        rd_lane = dmem_rdata >> {off_q, 3'b000};
        case (f3_q)
            3'b000:  load_val = {{24{rd_lane[7]}}, rd_lane[7:0]};
            3'b100:  load_val = {24'd0, rd_lane[7:0]};
            3'b001:  load_val = {{16{rd_lane[15]}}, rd_lane[15:0]};
            3'b101:  load_val = {16'd0, rd_lane[15:0]};
            default: load_val = rd_lane;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        off_d      = off_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        f3_d       = f3_q;
        rd_d       = rd_q;
        wb_valid_d = 1'b0;
        wb_data_d  = wb_data_q;
        wb_rd_d    = wb_rd_q;
        mem_exc_d  = 1'b0;
        bus_err_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (valid_in) begin
                    if (!mem_read && !mem_write) begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = alu_res;
                        wb_rd_d    = rd_in;
                    end else if (!op_legal) begin
                        mem_exc_d = 1'b1;
                    end else begin
                        state_d = ST_REQ;
                        cnt_d   = '0;
                        we_d    = mem_write;
                        addr_d  = {alu_res[31:2], 2'b00};
                        off_d   = alu_res[1:0];
                        be_d    = lane_be(funct3, alu_res[1:0]);
                        wdata_d = mem_write ? store_fmt(funct3, mem_data) : 32'd0;
                        f3_d    = funct3;
                        rd_d    = rd_in;
                    end
                end
            end
            ST_REQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (dmem_gnt && we_q) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == LAST_CNT) begin
                    state_d   = ST_IDLE;
                    bus_err_d = 1'b1;
                end else if (dmem_gnt) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (dmem_rvalid) begin
                    state_d    = ST_IDLE;
                    wb_valid_d = 1'b1;
                    wb_data_d  = load_val;
                    wb_rd_d    = rd_q;
                end else if (cnt_q == LAST_CNT) begin
                    state_d   = ST_IDLE;
                    bus_err_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        stall_d = (state_d != ST_IDLE);
        req_d   = (state_d == ST_REQ);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            off_q      <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            f3_q       <= '0;
            rd_q       <= '0;
            stall_q    <= 1'b0;
            req_q      <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_rd_q    <= '0;
            mem_exc_q  <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            off_q      <= off_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            f3_q       <= f3_d;
            rd_q       <= rd_d;
            stall_q    <= stall_d;
            req_q      <= req_d;
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
            wb_rd_q    <= wb_rd_d;
            mem_exc_q  <= mem_exc_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign stall      = stall_q;
    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_be    = be_q;
    assign dmem_wdata = wdata_q;
    assign wb_valid   = wb_valid_q;
    assign wb_data    = wb_data_q;
    assign wb_rd      = wb_rd_q;
    assign mem_exc    = mem_exc_q;
    assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: ALU passthrough, stores, loads,
// illegal accesses, bus timeout and asynchronous reset mid-transaction.
module tb_mem_access_stage;

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic [31:0] alu_res;
    logic [31:0] mem_data;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [4:0]  rd_in;
    logic        stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        mem_exc;
    logic        bus_err;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    mem_access_stage #(.MAX_WAIT(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .valid_in    (valid_in),
        .alu_res     (alu_res),
        .mem_data    (mem_data),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .funct3      (funct3),
        .rd_in       (rd_in),
        .stall       (stall),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_be     (dmem_be),
        .dmem_wdata  (dmem_wdata),
        .dmem_gnt    (dmem_gnt),
        .dmem_rvalid (dmem_rvalid),
        .dmem_rdata  (dmem_rdata),
        .wb_valid    (wb_valid),
        .wb_data     (wb_data),
        .wb_rd       (wb_rd),
        .mem_exc     (mem_exc),
        .bus_err     (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one instruction for exactly one clock edge.
    task automatic drive_op(input logic rd_op, input logic wr_op, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] d, input logic [4:0] r);
        valid_in  = 1'b1;
        mem_read  = rd_op;
        mem_write = wr_op;
        funct3    = f3;
        alu_res   = a;
        mem_data  = d;
        rd_in     = r;
        tick();
        valid_in  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    // Load with immediate grant and rvalid two cycles after the grant.
    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [4:0] r, input logic [3:0] exp_be,
                           input logic [31:0] rdata, input logic [31:0] exp_data);
        drive_op(1'b1, 1'b0, f3, a, 32'h0, r);
        check({tag, "_req"}, 32'(dmem_req), 32'd1);
        check({tag, "_we"}, 32'(dmem_we), 32'd0);
        check({tag, "_addr"}, dmem_addr, {a[31:2], 2'b00});
        check({tag, "_be"}, 32'(dmem_be), 32'(exp_be));
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        check({tag, "_req_drop"}, 32'(dmem_req), 32'd0);
        check({tag, "_stall_wait"}, 32'(stall), 32'd1);
        tick();
        check({tag, "_no_early_wb"}, 32'(wb_valid), 32'd0);
        dmem_rvalid = 1'b1;
        dmem_rdata  = rdata;
        tick();
        dmem_rvalid = 1'b0;
        check({tag, "_wb_valid"}, 32'(wb_valid), 32'd1);
        check({tag, "_wb_data"}, wb_data, exp_data);
        check({tag, "_wb_rd"}, 32'(wb_rd), 32'(r));
        check({tag, "_stall_done"}, 32'(stall), 32'd0);
    endtask

    initial begin
        rst         = 1'b0;
        valid_in    = 1'b0;
        alu_res     = '0;
        mem_data    = '0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        funct3      = '0;
        rd_in       = '0;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = '0;

        repeat (2) tick();
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_req", 32'(dmem_req), 32'd0);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_addr", dmem_addr, 32'd0);
        check("rst_exc", 32'(mem_exc), 32'd0);
        check("rst_bus_err", 32'(bus_err), 32'd0);
        rst = 1'b1;
        tick();

        // ALU passthrough
        drive_op(1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0, 5'd5);
        check("alu_wb_valid", 32'(wb_valid), 32'd1);
        check("alu_wb_data", wb_data, 32'h0000_1234);
        check("alu_wb_rd", 32'(wb_rd), 32'd5);
        check("alu_req", 32'(dmem_req), 32'd0);
        check("alu_stall", 32'(stall), 32'd0);
        tick();
        check("alu_pulse", 32'(wb_valid), 32'd0);
        check("alu_hold", wb_data, 32'h0000_1234);

        // SB with immediate grant
        drive_op(1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'h0000_00AB, 5'd0);
        check("sb_req", 32'(dmem_req), 32'd1);
        check("sb_we", 32'(dmem_we), 32'd1);
        check("sb_addr", dmem_addr, 32'h0000_0100);
        check("sb_be", 32'(dmem_be), 32'h8);
        check("sb_wdata", dmem_wdata, 32'hABAB_ABAB);
        check("sb_stall", 32'(stall), 32'd1);
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        check("sb_stall_end", 32'(stall), 32'd0);
        check("sb_req_end", 32'(dmem_req), 32'd0);
        check("sb_no_wb", 32'(wb_valid), 32'd0);

        // SH upper half
        drive_op(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h1234_BEEF, 5'd0);
        check("sh_be", 32'(dmem_be), 32'hC);
        check("sh_wdata", dmem_wdata, 32'hBEEF_BEEF);
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        check("sh_stall_end", 32'(stall), 32'd0);

        // SW with grant delayed two cycles: request stays stable
        drive_op(1'b0, 1'b1, 3'b010, 32'h0000_0300, 32'hDEAD_BEEF, 5'd0);
        tick();
        tick();
        check("sw_req_held", 32'(dmem_req), 32'd1);
        check("sw_addr_held", dmem_addr, 32'h0000_0300);
        check("sw_be", 32'(dmem_be), 32'hF);
        check("sw_wdata", dmem_wdata, 32'hDEAD_BEEF);
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        check("sw_done", 32'(stall), 32'd0);

        // Loads
        do_load("lh",  3'b001, 32'h0000_0102, 5'd9,  4'hC, 32'h8001_0000, 32'hFFFF_8001);
        do_load("lhu", 3'b101, 32'h0000_0102, 5'd10, 4'hC, 32'h8001_0000, 32'h0000_8001);
        do_load("lb",  3'b000, 32'h0000_0101, 5'd11, 4'h2, 32'h0000_7F00, 32'h0000_007F);
        do_load("lbn", 3'b000, 32'h0000_0103, 5'd12, 4'h8, 32'h8000_0000, 32'hFFFF_FF80);
        do_load("lw",  3'b010, 32'h0000_0104, 5'd13, 4'hF, 32'h1234_5678, 32'h1234_5678);

        // rvalid together with gnt in REQ is ignored
        drive_op(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0, 5'd14);
        dmem_gnt    = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h1111_1111;
        tick();
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        check("gr_same_no_wb", 32'(wb_valid), 32'd0);
        check("gr_same_stall", 32'(stall), 32'd1);
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h0000_0055;
        tick();
        dmem_rvalid = 1'b0;
        check("gr_same_wb", 32'(wb_valid), 32'd1);
        check("gr_same_data", wb_data, 32'h0000_0055);

        // Illegal accesses
        drive_op(1'b1, 1'b0, 3'b010, 32'h0000_0002, 32'h0, 5'd1);
        check("lw_mis_exc", 32'(mem_exc), 32'd1);
        check("lw_mis_req", 32'(dmem_req), 32'd0);
        check("lw_mis_stall", 32'(stall), 32'd0);
        tick();
        check("lw_mis_pulse", 32'(mem_exc), 32'd0);
        check("lw_mis_req2", 32'(dmem_req), 32'd0);
        drive_op(1'b1, 1'b1, 3'b000, 32'h0000_0100, 32'h0, 5'd1);
        check("rw_exc", 32'(mem_exc), 32'd1);
        check("rw_req", 32'(dmem_req), 32'd0);
        drive_op(1'b0, 1'b1, 3'b100, 32'h0000_0100, 32'h0, 5'd0);
        check("sbu_exc", 32'(mem_exc), 32'd1);
        drive_op(1'b1, 1'b0, 3'b001, 32'h0000_0101, 32'h0, 5'd2);
        check("lh_mis_exc", 32'(mem_exc), 32'd1);
        drive_op(1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'h0, 5'd2);
        check("bad_f3_exc", 32'(mem_exc), 32'd1);
        tick();

        // Bus timeout with the next instruction held at the inputs
        drive_op(1'b1, 1'b0, 3'b010, 32'h0000_0500, 32'h0, 5'd15);
        valid_in = 1'b1;
        alu_res  = 32'h0000_CAFE;
        rd_in    = 5'd7;
        check("to_stall0", 32'(stall), 32'd1);
        for (int i = 1; i < 16; i++) begin
            tick();
            check("to_stall_hold", 32'(stall), 32'd1);
            check("to_no_err", 32'(bus_err), 32'd0);
        end
        tick();
        check("to_bus_err", 32'(bus_err), 32'd1);
        check("to_stall_drop", 32'(stall), 32'd0);
        check("to_req_drop", 32'(dmem_req), 32'd0);
        check("to_no_wb", 32'(wb_valid), 32'd0);
        tick();
        valid_in = 1'b0;
        check("to_next_wb", 32'(wb_valid), 32'd1);
        check("to_next_data", wb_data, 32'h0000_CAFE);
        check("to_next_rd", 32'(wb_rd), 32'd7);
        check("to_err_pulse", 32'(bus_err), 32'd0);

        // Reset during REQ drops the request at once
        drive_op(1'b1, 1'b0, 3'b010, 32'h0000_0600, 32'h0, 5'd3);
        check("rreq_req_pre", 32'(dmem_req), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("rreq_req_async", 32'(dmem_req), 32'd0);
        check("rreq_stall_async", 32'(stall), 32'd0);
        @(posedge clk);
        #3 rst = 1'b1;
        tick();

        // Reset during WAIT; a late rvalid must not produce writeback
        drive_op(1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0, 5'd13);
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        check("rwait_stall_pre", 32'(stall), 32'd1);
        #3 rst = 1'b0;
        #1;
        check("rwait_stall", 32'(stall), 32'd0);
        check("rwait_req", 32'(dmem_req), 32'd0);
        check("rwait_wb", 32'(wb_valid), 32'd0);
        @(posedge clk);
        #3 rst = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h0000_FFFF;
        tick();
        dmem_rvalid = 1'b0;
        check("rwait_late_wb", 32'(wb_valid), 32'd0);
        check("rwait_late_stall", 32'(stall), 32'd0);
        tick();
        check("rwait_late_wb2", 32'(wb_valid), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
